memory_access: RTL and testbench

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/mem_pkg.sv | 76 +++++++
 rtl/load_align.sv | 26 ++
 rtl/memory_access.sv | 197 +++++++++++++++++++
 tb/tb_memory_access.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants, state encoding and decode helpers for the memory-access stage.
package mem_pkg;

    // Major opcodes handled by the stage
    localparam logic [6:0] OpcLoad  = 7'b0000011;
    localparam logic [6:0] OpcStore = 7'b0100011;

    // funct3 access size / sign selectors
    localparam logic [2:0] F3Byte  = 3'b000;
    localparam logic [2:0] F3Half  = 3'b001;
    localparam logic [2:0] F3Word  = 3'b010;
    localparam logic [2:0] F3ByteU = 3'b100;
    localparam logic [2:0] F3HalfU = 3'b101;

    // Fault codes reported alongside valid_out
    localparam logic [1:0] FaultNone       = 2'b00;
    localparam logic [1:0] FaultMisaligned = 2'b01;
    localparam logic [1:0] FaultIllegal    = 2'b10;
    localparam logic [1:0] FaultTimeout    = 2'b11;

    // Number of non-ack cycles tolerated before the access is abandoned
    localparam logic [7:0] TimeoutCycles = 8'd255;

    typedef enum logic {
        StIdle,
        StAccess
    } state_e;

    // Legal funct3 encodings for the given memory opcode
    function automatic logic f3_legal(input logic [6:0] opcode, input logic [2:0] funct3);
        logic ok;
        ok = 1'b0;
        if (opcode == OpcLoad) begin
            ok = (funct3 == F3Byte) || (funct3 == F3Half) || (funct3 == F3Word) ||
                 (funct3 == F3ByteU) || (funct3 == F3HalfU);
        end else if (opcode == OpcStore) begin
            ok = (funct3 == F3Byte) || (funct3 == F3Half) || (funct3 == F3Word);
        end
        return ok;
    endfunction

    // Size is encoded in funct3[1:0] for every legal load/store
    function automatic logic addr_aligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic ok;
        case (funct3[1:0])
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~addr_lo[0];
            default: ok = (addr_lo == 2'b00);
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [2:0] funct3,
                                               input logic [1:0] addr_lo);
        logic [3:0] be;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << addr_lo;
            2'b01:   be = 4'b0011 << addr_lo;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store operand so it appears in whichever lanes are enabled
    function automatic logic [31:0] store_data(input logic [2:0] funct3,
                                               input logic [31:0] rs2);
        logic [31:0] d;
        case (funct3[1:0])
            2'b00:   d = {4{rs2[7:0]}};
            2'b01:   d = {2{rs2[15:0]}};
            default: d = rs2;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational lane extraction and sign/zero extension of load data.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    // Move the addressed byte/half down to bit 0, then extend per funct3
    always_comb begin
        shifted = rdata_i >> {offset_i, 3'b000};
        data_o  = shifted;
        case (funct3_i)
            F3Byte:  data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3ByteU: data_o = {24'h000000, shifted[7:0]};
            F3Half:  data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3HalfU: data_o = {16'h0000, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Pipeline memory-access stage: passes ALU results through in one cycle and
// runs loads/stores against a req/ack data-memory port with timeout.
module memory_access
    import mem_pkg::*;
(
    input  logic        req,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        valid_in,
    input  logic [6:0]  opcode_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] result_in,
    input  logic [31:0] rs2_value_in,
    input  logic [4:0]  rd_in,
    input  logic        rd_write_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_out,
    output logic        valid_out,
    output logic [4:0]  rd_out,
    output logic        rd_write_out,
    output logic [31:0] result_out,
    output logic [1:0]  fault_out
);

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        valid_q, valid_d;
    logic [4:0]  rd_q, rd_d;
    logic        rd_write_q, rd_write_d;
    logic [31:0] result_q, result_d;
    logic [1:0]  fault_q, fault_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  offset_q, offset_d;
    logic        rd_write_pend_q, rd_write_pend_d;

    logic        accept;
    logic        mem_op;
    logic        legal;
    logic        aligned;
    logic        go_access;
    logic [31:0] load_data;

    load_align u_load_align (
        .rdata_i  (dmem_rdata),
        .offset_i (offset_q),
        .funct3_i (funct3_q),
        .data_o   (load_data)
    );

    // Decode of the incoming operation; acceptance is suppressed during reset
    always_comb begin
        accept    = (state_q == StIdle) && valid_in && !stall_in && !reset;
        mem_op    = (opcode_in == OpcLoad) || (opcode_in == OpcStore);
        legal     = f3_legal(opcode_in, funct3_in);
        aligned   = addr_aligned(funct3_in, result_in[1:0]);
        go_access = accept && mem_op && legal && aligned;
        stall_out = (state_q == StAccess) || go_access;
    end

    // Next-state logic: accept/decode in idle, wait for ack or timeout in access
    always_comb begin
        state_d         = state_q;
        req_d           = req_q;
        we_d            = we_q;
        addr_d          = addr_q;
        be_d            = be_q;
        wdata_d         = wdata_q;
        valid_d         = 1'b0;
        rd_d            = rd_q;
        rd_write_d      = rd_write_q;
        result_d        = result_q;
        fault_d         = fault_q;
        wait_cnt_d      = wait_cnt_q;
        funct3_d        = funct3_q;
        offset_d        = offset_q;
        rd_write_pend_d = rd_write_pend_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    rd_d = rd_in;
                    if (!mem_op) begin
                        valid_d    = 1'b1;
                        result_d   = result_in;
                        rd_write_d = rd_write_in;
                        fault_d    = FaultNone;
                    end else if (!legal) begin
                        // Illegal funct3 wins over misalignment
                        valid_d    = 1'b1;
                        rd_write_d = 1'b0;
                        fault_d    = FaultIllegal;
                    end else if (!aligned) begin
                        valid_d    = 1'b1;
                        rd_write_d = 1'b0;
                        fault_d    = FaultMisaligned;
                    end else begin
                        state_d         = StAccess;
                        req_d           = 1'b1;
                        we_d            = (opcode_in == OpcStore);
                        addr_d          = {result_in[31:2], 2'b00};
                        be_d            = byte_enable(funct3_in, result_in[1:0]);
                        wdata_d         = store_data(funct3_in, rs2_value_in);
                        wait_cnt_d      = 8'd0;
                        funct3_d        = funct3_in;
                        offset_d        = result_in[1:0];
                        rd_write_pend_d = rd_write_in;
                    end
                end
            end
            StAccess: begin
                if (dmem_ack) begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    fault_d = FaultNone;
                    if (we_q) begin
                        rd_write_d = 1'b0;
                    end else begin
                        rd_write_d = rd_write_pend_q;
                        result_d   = load_data;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    // This is the last tolerated non-ack cycle: give up
                    if (wait_cnt_q == TimeoutCycles - 8'd1) begin
                        state_d    = StIdle;
                        req_d      = 1'b0;
                        valid_d    = 1'b1;
                        rd_write_d = 1'b0;
                        fault_d    = FaultTimeout;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset that clears every output
    always_ff @(posedge req) begin
        if (reset) begin
            state_q         <= StIdle;
            req_q           <= 1'b0;
            we_q            <= 1'b0;
            addr_q          <= 32'h0;
            be_q            <= 4'h0;
            wdata_q         <= 32'h0;
            valid_q         <= 1'b0;
            rd_q            <= 5'h0;
            rd_write_q      <= 1'b0;
            result_q        <= 32'h0;
            fault_q         <= FaultNone;
            wait_cnt_q      <= 8'd0;
            funct3_q        <= 3'b000;
            offset_q        <= 2'b00;
            rd_write_pend_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            req_q           <= req_d;
            we_q            <= we_d;
            addr_q          <= addr_d;
            be_q            <= be_d;
            wdata_q         <= wdata_d;
            valid_q         <= valid_d;
            rd_q            <= rd_d;
            rd_write_q      <= rd_write_d;
            result_q        <= result_d;
            fault_q         <= fault_d;
            wait_cnt_q      <= wait_cnt_d;
            funct3_q        <= funct3_d;
            offset_q        <= offset_d;
            rd_write_pend_q <= rd_write_pend_d;
        end
    end

    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_be      = be_q;
    assign dmem_wdata   = wdata_q;
    assign valid_out    = valid_q;
    assign rd_out       = rd_q;
    assign rd_write_out = rd_write_q;
    assign result_out   = result_q;
    assign fault_out    = fault_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: pass-through, loads, stores, faults,
// timeout, stall gating and reset abort.
module tb_memory_access;

    logic        clk;
    logic        reset;
    logic        stall_in;
    logic        valid_in;
    logic [6:0]  opcode_in;
    logic [2:0]  funct3_in;
    logic [31:0] result_in;
    logic [31:0] rs2_value_in;
    logic [4:0]  rd_in;
    logic        rd_write_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall_out;
    logic        valid_out;
    logic [4:0]  rd_out;
    logic        rd_write_out;
    logic [31:0] result_out;
    logic [1:0]  fault_out;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    memory_access dut (
        .req          (clk),
        .reset        (reset),
        .stall_in     (stall_in),
        .valid_in     (valid_in),
        .opcode_in    (opcode_in),
        .funct3_in    (funct3_in),
        .result_in    (result_in),
        .rs2_value_in (rs2_value_in),
        .rd_in        (rd_in),
        .rd_write_in  (rd_write_in),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_ack     (dmem_ack),
        .stall_out    (stall_out),
        .valid_out    (valid_out),
        .rd_out       (rd_out),
        .rd_write_out (rd_write_out),
        .result_out   (result_out),
        .fault_out    (fault_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] res,
                         input logic [31:0] rs2, input logic [4:0] rd, input logic rdw);
        valid_in     = 1'b1;
        opcode_in    = op;
        funct3_in    = f3;
        result_in    = res;
        rs2_value_in = rs2;
        rd_in        = rd;
        rd_write_in  = rdw;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b want 0", dmem_req); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", valid_out); end
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b want 0", stall_out); end
        checks++; if (fault_out !== 2'b00) begin errors++; $display("FAIL rst_fault got %0b want 00", fault_out); end
        checks++; if (result_out !== 32'h0) begin errors++; $display("FAIL rst_result got %h want 0", result_out); end
        checks++; if (dmem_be !== 4'h0) begin errors++; $display("FAIL rst_be got %b want 0000", dmem_be); end
    endtask

    task automatic test_alu();
        drive(OP_ALU, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
        #1;
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL alu_stall got %0b want 0", stall_out); end
        step();
        valid_in = 1'b0;
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL alu_valid got %0b want 1", valid_out); end
        checks++; if (result_out !== 32'h0000_1234) begin errors++; $display("FAIL alu_result got %h want 00001234", result_out); end
        checks++; if (rd_out !== 5'd5) begin errors++; $display("FAIL alu_rd got %0d want 5", rd_out); end
        checks++; if (rd_write_out !== 1'b1) begin errors++; $display("FAIL alu_rdw got %0b want 1", rd_write_out); end
        checks++; if (fault_out !== 2'b00) begin errors++; $display("FAIL alu_fault got %0b want 00", fault_out); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL alu_req got %0b want 0", dmem_req); end
        step();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL alu_pulse got %0b want 0", valid_out); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL alu_req2 got %0b want 0", dmem_req); end
    endtask

    task automatic test_lb_wait();
        drive(OP_LOAD, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1'b1);
        #1;
        checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL lb_accept_stall got %0b want 1", stall_out); end
        step();
        valid_in = 1'b0;
        checks++; if (dmem_addr !== 32'h0000_0100) begin errors++; $display("FAIL lb_addr got %h want 00000100", dmem_addr); end
        checks++; if (dmem_be !== 4'b1000) begin errors++; $display("FAIL lb_be got %b want 1000", dmem_be); end
        checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL lb_we got %0b want 0", dmem_we); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || dmem_be !== 4'b1000) begin
                errors++; $display("FAIL lb_hold%0d got req=%0b addr=%h be=%b want 1/100/1000", i, dmem_req, dmem_addr, dmem_be);
            end
            checks++; if (valid_out !== 1'b0 || stall_out !== 1'b1) begin
                errors++; $display("FAIL lb_wait%0d got valid=%0b stall=%0b want 0/1", i, valid_out, stall_out);
            end
            step();
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h80AB_CDEF;
        step();
        dmem_ack   = 1'b0;
        checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL lb_valid got %0b want 1", valid_out); end
        checks++; if (result_out !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_result got %h want ffffff80", result_out); end
        checks++; if (rd_out !== 5'd7 || rd_write_out !== 1'b1) begin errors++; $display("FAIL lb_rd got %0d/%0b want 7/1", rd_out, rd_write_out); end
        checks++; if (dmem_req !== 1'b0 || stall_out !== 1'b0) begin errors++; $display("FAIL lb_done got req=%0b stall=%0b want 0/0", dmem_req, stall_out); end
        step();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL lb_pulse got %0b want 0", valid_out); end
        checks++; if (result_out !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_hold_result got %h want ffffff80", result_out); end
    endtask

    task automatic test_sh();
        drive(OP_STORE, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 5'd3, 1'b1);
        step();
        valid_in = 1'b0;
        checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin errors++; $display("FAIL sh_req got req=%0b we=%0b want 1/1", dmem_req, dmem_we); end
        checks++; if (dmem_be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b want 1100", dmem_be); end
        checks++; if (dmem_wdata[31:16] !== 16'hBEEF) begin errors++; $display("FAIL sh_wdata got %h want beef", dmem_wdata[31:16]); end
        checks++; if (dmem_addr !== 32'h0000_0200) begin errors++; $display("FAIL sh_addr got %h want 00000200", dmem_addr); end
        step();
        checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL sh_stall got %0b want 1", stall_out); end
        dmem_ack = 1'b1;
        #1;
        checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL sh_stall_ack got %0b want 1", stall_out); end
        step();
        dmem_ack = 1'b0;
        checks++; if (valid_out !== 1'b1 || rd_write_out !== 1'b0) begin errors++; $display("FAIL sh_done got valid=%0b rdw=%0b want 1/0", valid_out, rd_write_out); end
        checks++; if (stall_out !== 1'b0 || fault_out !== 2'b00) begin errors++; $display("FAIL sh_idle got stall=%0b fault=%0b want 0/00", stall_out, fault_out); end
        step();
    endtask

    // Minimum-latency loads: ack already high at accept (ignored in idle) and on first req cycle
    task automatic test_load_variants();
        logic [2:0]  f3  [5] = '{3'b010, 3'b001, 3'b101, 3'b100, 3'b000};
        logic [31:0] adr [5] = '{32'h40, 32'h42, 32'h42, 32'h41, 32'h40};
        logic [31:0] rdt [5] = '{32'hDEAD_BEEF, 32'hABCD_1234, 32'hABCD_1234, 32'hABCD_1234, 32'h0000_007F};
        logic [31:0] exp [5] = '{32'hDEAD_BEEF, 32'hFFFF_ABCD, 32'h0000_ABCD, 32'h0000_0012, 32'h0000_007F};
        for (int i = 0; i < 5; i++) begin
            drive(OP_LOAD, f3[i], adr[i], 32'h0, 5'd9, 1'b1);
            dmem_ack   = 1'b1;
            dmem_rdata = rdt[i];
            step();
            valid_in = 1'b0;
            checks++; if (dmem_req !== 1'b1 || valid_out !== 1'b0) begin
                errors++; $display("FAIL ld%0d_first got req=%0b valid=%0b want 1/0", i, dmem_req, valid_out);
            end
            step();
            dmem_ack = 1'b0;
            checks++; if (valid_out !== 1'b1 || result_out !== exp[i]) begin
                errors++; $display("FAIL ld%0d_result got valid=%0b data=%h want 1/%h", i, valid_out, result_out, exp[i]);
            end
            step();
        end
    endtask

    task automatic test_faults();
        logic [6:0]  op  [5] = '{OP_LOAD, OP_LOAD, OP_LOAD, OP_STORE, OP_STORE};
        logic [2:0]  f3  [5] = '{3'b010, 3'b011, 3'b001, 3'b100, 3'b010};
        logic [31:0] adr [5] = '{32'h301, 32'h300, 32'h103, 32'h301, 32'h302};
        logic [1:0]  exp [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        for (int i = 0; i < 5; i++) begin
            drive(op[i], f3[i], adr[i], 32'h0, 5'd4, 1'b1);
            #1;
            checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL flt%0d_stall got %0b want 0", i, stall_out); end
            step();
            valid_in = 1'b0;
            checks++; if (valid_out !== 1'b1 || fault_out !== exp[i] || rd_write_out !== 1'b0 || dmem_req !== 1'b0) begin
                errors++; $display("FAIL flt%0d got valid=%0b fault=%b rdw=%0b req=%0b want 1/%b/0/0",
                                   i, valid_out, fault_out, rd_write_out, dmem_req, exp[i]);
            end
            step();
            checks++; if (valid_out !== 1'b0 || dmem_req !== 1'b0) begin
                errors++; $display("FAIL flt%0d_after got valid=%0b req=%0b want 0/0", i, valid_out, dmem_req);
            end
        end
    endtask

    task automatic test_stall();
        drive(OP_ALU, 3'b000, 32'h55, 32'h0, 5'd1, 1'b1);
        stall_in = 1'b1;
        step();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL stall_gate got %0b want 0", valid_out); end
        stall_in = 1'b0;
        drive(OP_STORE, 3'b000, 32'h3, 32'h0000_005A, 5'd1, 1'b1);
        step();
        valid_in = 1'b0;
        checks++; if (dmem_be !== 4'b1000 || dmem_wdata !== 32'h5A5A_5A5A) begin
            errors++; $display("FAIL sb_lane got be=%b wdata=%h want 1000/5a5a5a5a", dmem_be, dmem_wdata);
        end
        stall_in = 1'b1;
        step();
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL stall_noabort got %0b want 1", dmem_req); end
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        checks++; if (valid_out !== 1'b1 || fault_out !== 2'b00) begin
            errors++; $display("FAIL stall_complete got valid=%0b fault=%b want 1/00", valid_out, fault_out);
        end
        stall_in = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int n;
        drive(OP_LOAD, 3'b010, 32'h400, 32'h0, 5'd2, 1'b1);
        step();
        valid_in = 1'b0;
        n = 0;
        while (dmem_req === 1'b1 && n < 300) begin
            n++;
            step();
        end
        checks++; if (n != 255) begin errors++; $display("FAIL tmo_cycles got %0d want 255", n); end
        checks++; if (valid_out !== 1'b1 || fault_out !== 2'b11 || rd_write_out !== 1'b0) begin
            errors++; $display("FAIL tmo_result got valid=%0b fault=%b rdw=%0b want 1/11/0", valid_out, fault_out, rd_write_out);
        end
        step();
        checks++; if (valid_out !== 1'b0 || stall_out !== 1'b0) begin
            errors++; $display("FAIL tmo_after got valid=%0b stall=%0b want 0/0", valid_out, stall_out);
        end
    endtask

    task automatic test_reset_mid_access();
        drive(OP_LOAD, 3'b010, 32'h500, 32'h0, 5'd9, 1'b1);
        step();
        valid_in = 1'b0;
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rma_req got %0b want 1", dmem_req); end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (dmem_req !== 1'b0 || stall_out !== 1'b0 || valid_out !== 1'b0) begin
            errors++; $display("FAIL rma_abort got req=%0b stall=%0b valid=%0b want 0/0/0", dmem_req, stall_out, valid_out);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1111_2222;
        step();
        dmem_ack = 1'b0;
        checks++; if (valid_out !== 1'b0 || dmem_req !== 1'b0 || result_out !== 32'h0) begin
            errors++; $display("FAIL rma_late_ack got valid=%0b req=%0b data=%h want 0/0/0", valid_out, dmem_req, result_out);
        end
    endtask

    initial begin
        reset        = 1'b1;
        stall_in     = 1'b0;
        valid_in     = 1'b0;
        opcode_in    = 7'h0;
        funct3_in    = 3'h0;
        result_in    = 32'h0;
        rs2_value_in = 32'h0;
        rd_in        = 5'h0;
        rd_write_in  = 1'b0;
        dmem_rdata   = 32'h0;
        dmem_ack     = 1'b0;

        test_reset();
        test_alu();
        test_lb_wait();
        test_sh();
        test_load_variants();
        test_faults();
        test_stall();
        test_timeout();
        test_reset_mid_access();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
